// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder buffer.
// Pure declarations: no logic, no latency.
// Not applicable for backpressure; widths mirror the reorder_buffer defaults.
package rob_pkg;

    localparam int ROB_AR_SIZE  = 6;
    localparam int ROB_DEPTH    = 16;
    localparam int ROB_DATA_W   = 32;
    localparam int ROB_TAG_W    = $clog2(ROB_DEPTH);
    localparam int RETIRE_WIDTH = 2;

    // One buffer slot. valid = allocated, done = result written back.
    typedef struct packed {
        logic                   valid;
        logic                   done;
        logic [ROB_AR_SIZE-1:0] rd;
        logic [ROB_DATA_W-1:0]  data;
    } rob_entry_t;

endpackage

// File: rtl/rob_retire_sel.sv
// Picks up to two completed head entries for in-order retirement.
// Purely combinational, zero latency.
// Slot 2 only retires behind slot 1, so an incomplete head stalls both.
module rob_retire_sel
    import rob_pkg::*;
#(
    parameter int TAG_W = ROB_TAG_W
) (
    input  logic [TAG_W-1:0]       i_head,
    input  rob_entry_t             i_entry0,
    input  rob_entry_t             i_entry1,
    output logic [TAG_W-1:0]       o_head_p1,
    output logic [TAG_W-1:0]       o_head_next,
    output logic                   o_retire1,
    output logic                   o_retire2,
    output logic [1:0]             o_n_retired,
    output logic [ROB_AR_SIZE-1:0] o_addr1,
    output logic [ROB_DATA_W-1:0]  o_data1,
    output logic [ROB_AR_SIZE-1:0] o_addr2,
    output logic [ROB_DATA_W-1:0]  o_data2
);

    // Decide retirement from the two oldest entries; unused slots drive zeros.
    always_comb begin
        o_head_p1   = i_head + TAG_W'(1);
        o_retire1   = i_entry0.valid & i_entry0.done;
        o_retire2   = o_retire1 & i_entry1.valid & i_entry1.done;
        o_n_retired = {1'b0, o_retire1} + {1'b0, o_retire2};
        // Natural wrap of the pointer: DEPTH is a power of two.
        o_head_next = i_head + TAG_W'(o_n_retired);
        o_addr1     = '0;
        o_data1     = '0;
        o_addr2     = '0;
        o_data2     = '0;
        if (o_retire1) begin
            o_addr1 = i_entry0.rd;
            o_data1 = i_entry0.data;
        end
        if (o_retire2) begin
            o_addr2 = i_entry1.rd;
            o_data2 = i_entry1.data;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: 1 alloc/cycle, 2 writebacks/cycle, 2 retires/cycle to the ARF.
// ARF writes are registered: they appear 1 cycle after the retire decision.
// alloc_ready drops when full; space freed by retirement is visible next cycle. Optional flush: ROB_FLUSH_EN.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter  int AR_SIZE = ROB_AR_SIZE,
    parameter  int DEPTH   = ROB_DEPTH,
    parameter  int DATA_W  = ROB_DATA_W,
    localparam int TAG_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc_valid,
    input  logic [AR_SIZE-1:0] alloc_rd,
    output logic               alloc_ready,
    output logic [TAG_W-1:0]   alloc_tag,
    input  logic               cmp_valid1,
    input  logic [TAG_W-1:0]   cmp_tag1,
    input  logic [DATA_W-1:0]  cmp_data1,
    input  logic               cmp_valid2,
    input  logic [TAG_W-1:0]   cmp_tag2,
    input  logic [DATA_W-1:0]  cmp_data2,
`ifdef ROB_FLUSH_EN
    input  logic               flush,
`endif
    output logic [AR_SIZE-1:0] write_addr1,
    output logic [DATA_W-1:0]  write_data1,
    output logic [AR_SIZE-1:0] write_addr2,
    output logic [DATA_W-1:0]  write_data2,
    output logic               write_en,
    output logic [TAG_W:0]     rob_count,
    output logic               rob_empty
);

    // Entry storage uses the package struct; its field widths track the package defaults.
    rob_entry_t           r_rob [DEPTH];
    logic [TAG_W-1:0]     r_head;
    logic [TAG_W-1:0]     r_tail;
    logic [TAG_W:0]       r_count;

    logic [AR_SIZE-1:0]   r_write_addr1;
    logic [DATA_W-1:0]    r_write_data1;
    logic [AR_SIZE-1:0]   r_write_addr2;
    logic [DATA_W-1:0]    r_write_data2;
    logic                 r_write_en;

    logic                 w_alloc_fire;
    logic                 w_cmp1_hit;
    logic                 w_cmp2_hit;
    logic [TAG_W-1:0]     w_head_p1;
    logic [TAG_W-1:0]     w_head_next;
    logic                 w_retire1;
    logic                 w_retire2;
    logic [1:0]           w_n_retired;
    logic [AR_SIZE-1:0]   w_addr1;
    logic [DATA_W-1:0]    w_data1;
    logic [AR_SIZE-1:0]   w_addr2;
    logic [DATA_W-1:0]    w_data2;
    logic [TAG_W:0]       w_count_next;
    rob_entry_t           w_new_entry;

    // Count disambiguates full from empty when head == tail.
    assign alloc_ready  = (r_count < (TAG_W+1)'(DEPTH));
    assign alloc_tag    = r_tail;
    assign w_alloc_fire = alloc_valid & alloc_ready;

    // Writebacks only land on allocated entries; stale tags are dropped.
    assign w_cmp1_hit   = cmp_valid1 & r_rob[cmp_tag1].valid;
    assign w_cmp2_hit   = cmp_valid2 & r_rob[cmp_tag2].valid;

    assign w_count_next = r_count + (TAG_W+1)'(w_alloc_fire) - (TAG_W+1)'(w_n_retired);

    assign rob_count    = r_count;
    assign rob_empty    = (r_count == '0);
    assign write_addr1  = r_write_addr1;
    assign write_data1  = r_write_data1;
    assign write_addr2  = r_write_addr2;
    assign write_data2  = r_write_data2;
    assign write_en     = r_write_en;

    // Freshly dispatched entry: allocated, not yet complete, result cleared.
    always_comb begin
        w_new_entry       = '0;
        w_new_entry.valid = 1'b1;
        w_new_entry.rd    = alloc_rd;
    end

    rob_retire_sel #(
        .TAG_W       (TAG_W)
    ) u_retire_sel (
        .i_head      (r_head),
        .i_entry0    (r_rob[r_head]),
        .i_entry1    (r_rob[w_head_p1]),
        .o_head_p1   (w_head_p1),
        .o_head_next (w_head_next),
        .o_retire1   (w_retire1),
        .o_retire2   (w_retire2),
        .o_n_retired (w_n_retired),
        .o_addr1     (w_addr1),
        .o_data1     (w_data1),
        .o_addr2     (w_addr2),
        .o_data2     (w_data2)
    );

    // Pointers, entry array and ARF write registers. Within a cycle later writes win:
    // port 2 over port 1, and retirement clears last so a late writeback cannot revive an entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rob[i] <= '0;
            end
            r_write_addr1 <= '0;
            r_write_data1 <= '0;
            r_write_addr2 <= '0;
            r_write_data2 <= '0;
            r_write_en    <= 1'b0;
        end
`ifdef ROB_FLUSH_EN
        else if (flush) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rob[i].valid <= 1'b0;
                r_rob[i].done  <= 1'b0;
            end
            r_write_addr1 <= '0;
            r_write_data1 <= '0;
            r_write_addr2 <= '0;
            r_write_data2 <= '0;
            r_write_en    <= 1'b0;
        end
`endif
        else begin
            if (w_cmp1_hit) begin
                r_rob[cmp_tag1].done <= 1'b1;
                r_rob[cmp_tag1].data <= cmp_data1;
            end
            if (w_cmp2_hit) begin
                r_rob[cmp_tag2].done <= 1'b1;
                r_rob[cmp_tag2].data <= cmp_data2;
            end
            if (w_alloc_fire) begin
                r_rob[r_tail] <= w_new_entry;
                r_tail        <= r_tail + TAG_W'(1);
            end
            if (w_retire1) begin
                r_rob[r_head] <= '0;
            end
            if (w_retire2) begin
                r_rob[w_head_p1] <= '0;
            end
            r_head        <= w_head_next;
            r_count       <= w_count_next;
            r_write_addr1 <= w_addr1;
            r_write_data1 <= w_data1;
            r_write_addr2 <= w_addr2;
            r_write_data2 <= w_data2;
            r_write_en    <= w_retire1;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios then randomized traffic.
// Reference model keeps program order as a queue of tags plus per-tag done/rd/data.
// Inputs change 1 time unit after posedge; outputs are sampled 2 units after posedge.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_valid;
    logic [5:0]  alloc_rd;
    logic        alloc_ready;
    logic [3:0]  alloc_tag;
    logic        cmp_valid1;
    logic [3:0]  cmp_tag1;
    logic [31:0] cmp_data1;
    logic        cmp_valid2;
    logic [3:0]  cmp_tag2;
    logic [31:0] cmp_data2;
`ifdef ROB_FLUSH_EN
    logic        flush;
`endif
    logic [5:0]  write_addr1;
    logic [31:0] write_data1;
    logic [5:0]  write_addr2;
    logic [31:0] write_data2;
    logic        write_en;
    logic [4:0]  rob_count;
    logic        rob_empty;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .alloc_ready (alloc_ready),
        .alloc_tag   (alloc_tag),
        .cmp_valid1  (cmp_valid1),
        .cmp_tag1    (cmp_tag1),
        .cmp_data1   (cmp_data1),
        .cmp_valid2  (cmp_valid2),
        .cmp_tag2    (cmp_tag2),
        .cmp_data2   (cmp_data2),
`ifdef ROB_FLUSH_EN
        .flush       (flush),
`endif
        .write_addr1 (write_addr1),
        .write_data1 (write_data1),
        .write_addr2 (write_addr2),
        .write_data2 (write_data2),
        .write_en    (write_en),
        .rob_count   (rob_count),
        .rob_empty   (rob_empty)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: q holds outstanding tags oldest first.
    int          q[$];
    bit          m_done [16];
    logic [5:0]  m_rd   [16];
    logic [31:0] m_data [16];
    int          m_tail;
    bit          e_en;
    logic [5:0]  e_a1, e_a2;
    logic [31:0] e_d1, e_d2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit in_q(input int t);
        foreach (q[i]) if (q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_tail = 0;
        e_en = 1'b0; e_a1 = '0; e_a2 = '0; e_d1 = '0; e_d2 = '0;
        for (int i = 0; i < 16; i++) m_done[i] = 1'b0;
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0; alloc_rd = '0;
        cmp_valid1 = 1'b0; cmp_tag1 = '0; cmp_data1 = '0;
        cmp_valid2 = 1'b0; cmp_tag2 = '0; cmp_data2 = '0;
`ifdef ROB_FLUSH_EN
        flush = 1'b0;
`endif
    endtask

    // Check all outputs against the model, advance the model by one cycle, clock the DUT.
    task automatic tick();
        bit r1, r2, fire, v1, v2, do_flush;
        #1;
        check("alloc_ready", alloc_ready, (q.size() < 16));
        check("alloc_tag",   alloc_tag,   m_tail);
        check("rob_count",   rob_count,   q.size());
        check("rob_empty",   rob_empty,   (q.size() == 0));
        check("write_en",    write_en,    e_en);
        check("write_addr1", write_addr1, e_a1);
        check("write_data1", write_data1, e_d1);
        check("write_addr2", write_addr2, e_a2);
        check("write_data2", write_data2, e_d2);
        do_flush = 1'b0;
`ifdef ROB_FLUSH_EN
        do_flush = flush;
`endif
        if (do_flush) begin
            model_reset();
        end else begin
            r1 = (q.size() > 0) && m_done[q[0]];
            r2 = r1 && (q.size() > 1) && m_done[q[1]];
            e_en = r1;
            e_a1 = r1 ? m_rd[q[0]]   : 6'd0;
            e_d1 = r1 ? m_data[q[0]] : 32'd0;
            e_a2 = r2 ? m_rd[q[1]]   : 6'd0;
            e_d2 = r2 ? m_data[q[1]] : 32'd0;
            fire = alloc_valid && (q.size() < 16);
            v1 = cmp_valid1 && in_q(int'(cmp_tag1));
            v2 = cmp_valid2 && in_q(int'(cmp_tag2));
            if (v1) begin m_done[cmp_tag1] = 1'b1; m_data[cmp_tag1] = cmp_data1; end
            if (v2) begin m_done[cmp_tag2] = 1'b1; m_data[cmp_tag2] = cmp_data2; end
            if (fire) begin
                q.push_back(m_tail);
                m_done[m_tail] = 1'b0;
                m_rd[m_tail]   = alloc_rd;
                m_tail         = (m_tail + 1) % 16;
            end
            if (r1) void'(q.pop_front());
            if (r2) void'(q.pop_front());
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic alloc(input logic [5:0] rd);
        alloc_valid = 1'b1; alloc_rd = rd;
    endtask

    task automatic cmp1(input logic [3:0] t, input logic [31:0] d);
        cmp_valid1 = 1'b1; cmp_tag1 = t; cmp_data1 = d;
    endtask

    task automatic cmp2(input logic [3:0] t, input logic [31:0] d);
        cmp_valid2 = 1'b1; cmp_tag2 = t; cmp_data2 = d;
    endtask

    initial begin
        int tg;
        // 1: reset state
        do_reset();
        check("rst_alloc_tag", alloc_tag, 0);
        check("rst_empty", rob_empty, 1);
        tick();

        // 2: dual retire
        do_reset();
        alloc(6'd5); tick();
        alloc(6'd7); tick();
        cmp1(4'd0, 32'hA); cmp2(4'd1, 32'hB); tick();
        tick();
        check("dual_en",    write_en,    1);
        check("dual_addr1", write_addr1, 5);
        check("dual_data1", write_data1, 32'hA);
        check("dual_addr2", write_addr2, 7);
        check("dual_data2", write_data2, 32'hB);
        check("dual_empty", rob_empty,   1);
        tick();

        // 3: in-order stall
        do_reset();
        alloc(6'd3); tick();
        alloc(6'd4); tick();
        cmp1(4'd1, 32'h11); tick();
        repeat (3) begin
            tick();
            check("stall_en", write_en, 0);
        end
        cmp2(4'd0, 32'h10); tick();
        tick();
        check("unstall_en",    write_en,    1);
        check("unstall_addr1", write_addr1, 3);
        check("unstall_data1", write_data1, 32'h10);
        check("unstall_addr2", write_addr2, 4);
        check("unstall_data2", write_data2, 32'h11);
        tick();

        // 4: full and wrap
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc(6'(i + 1)); tick();
        end
        check("full_ready", alloc_ready, 0);
        check("full_count", rob_count, 16);
        alloc(6'd33); tick();
        check("full_ignored", rob_count, 16);
        cmp1(4'd0, 32'h100); cmp2(4'd1, 32'h101); tick();
        tick();
        check("wrap_ready", alloc_ready, 1);
        check("wrap_tag0", alloc_tag, 0);
        alloc(6'd40); tick();
        check("wrap_tag1", alloc_tag, 1);
        alloc(6'd41); tick();
        for (int i = 15; i >= 2; i -= 2) begin
            cmp1(4'(i), 32'h200 + i); cmp2(4'(i - 1), 32'h200 + i - 1); tick();
        end
        cmp1(4'd1, 32'h301); cmp2(4'd0, 32'h300); tick();
        repeat (10) tick();
        check("drain_empty", rob_empty, 1);

        // 5: single retire and stale completion
        do_reset();
        alloc(6'd9); tick();
        alloc(6'd10); tick();
        cmp1(4'd0, 32'h55); cmp2(4'd5, 32'h99); tick();
        tick();
        check("single_en",    write_en,    1);
        check("single_addr2", write_addr2, 0);
        check("single_data2", write_data2, 0);
        check("single_count", rob_count,   1);
        cmp1(4'd1, 32'h66); cmp2(4'd1, 32'h77); tick();
        tick();
        check("port2_wins", write_data1, 32'h77);
        tick();

`ifdef ROB_FLUSH_EN
        // 6: flush overrides a same-cycle alloc
        do_reset();
        for (int i = 0; i < 5; i++) begin
            alloc(6'(i + 1)); tick();
        end
        cmp1(4'd0, 32'h1);
        tick();
        flush = 1'b1; alloc(6'd20); tick();
        check("flush_count", rob_count, 0);
        check("flush_en",    write_en,  0);
        check("flush_tag",   alloc_tag, 0);
        tick();
`endif

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) < 6) alloc(6'($urandom_range(0, 63)));
            if ($urandom_range(0, 9) < 5) begin
                tg = (q.size() > 0 && $urandom_range(0, 9) < 8) ?
                     q[$urandom_range(0, q.size() - 1)] : int'($urandom_range(0, 15));
                cmp1(4'(tg), $urandom);
            end
            if ($urandom_range(0, 9) < 4) begin
                tg = (q.size() > 0 && $urandom_range(0, 9) < 8) ?
                     q[$urandom_range(0, q.size() - 1)] : int'($urandom_range(0, 15));
                cmp2(4'(tg), $urandom);
            end
`ifdef ROB_FLUSH_EN
            if ($urandom_range(0, 199) == 0) flush = 1'b1;
`endif
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
